// File: rtl/enc_pkg.sv
// ----------------------------------------------------------------------------
// enc_pkg
// Shared types and helpers for the encoder family.
//   state_e   : serializer state (IDLE waits for a vector, EMIT drains it)
//   enc_idx_w : width of a binary index able to address n positions
// ----------------------------------------------------------------------------
package enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic int enc_idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/prio_lsb_find.sv
// ----------------------------------------------------------------------------
// prio_lsb_find
// Combinational lowest-set-bit finder.
// Ports:
//   vec    in  N  vector to search
//   idx    out W  index of the lowest set bit (0 when vec is all zero)
//   found  out 1  at least one bit of vec is set
//   onehot out 1  exactly one bit of vec is set
// ----------------------------------------------------------------------------
module prio_lsb_find
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = enc_idx_w(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found,
  output logic         onehot
);

  logic hit_s;

  // Scan upward and latch the first set bit seen.
  always_comb begin
    idx   = '0;
    hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i] && !hit_s) begin
        idx   = W'(i);
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign found = |vec;

  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign onehot = found & ((vec & (vec - {{(N-1){1'b0}}, 1'b1})) == '0);

endmodule

// File: rtl/prio_enc_serializer.sv
// ----------------------------------------------------------------------------
// prio_enc_serializer
// Accepts an N-bit request vector and emits the index of every set bit,
// lowest first, one index per beat, with a last marker on the final beat.
// Build option: PRIO_ENC_ZERO_FLAG_EN -- when defined, an all-zero vector
// produces one beat flagged on the zero port; otherwise it is dropped and
// the zero port does not exist.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   en                     gates acceptance of new vectors only
//   in_valid/in_ready/a    input handshake and request vector
//   out_valid/out_ready    output handshake
//   y, last                index of lowest pending bit, final-beat marker
//   zero                   all-zero vector beat (option only)
//   busy                   a vector is being drained
// ----------------------------------------------------------------------------
module prio_enc_serializer
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = enc_idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         last,
`ifdef PRIO_ENC_ZERO_FLAG_EN
  output logic         zero,
`endif
  output logic         busy
);

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] clr_mask_s;
  logic [W-1:0] idx_s;
  logic         found_s;
  logic         onehot_s;
  logic         last_s;
`ifdef PRIO_ENC_ZERO_FLAG_EN
  logic         zero_q, zero_d;
`endif

  prio_lsb_find #(.N(N)) u_find (
    .vec    (pend_q),
    .idx    (idx_s),
    .found  (found_s),
    .onehot (onehot_s)
  );

  // Everything visible downstream is decoded from registered state only.
  assign out_valid  = (state_q == EMIT);
  assign busy       = (state_q == EMIT);
  assign in_ready   = (state_q == IDLE) & en & ~rst;
  assign clr_mask_s = {{(N-1){1'b0}}, 1'b1} << idx_s;

`ifdef PRIO_ENC_ZERO_FLAG_EN
  // The all-zero beat has an empty pend, so it is final by construction.
  assign last_s = zero_q | onehot_s;
  assign zero   = out_valid & zero_q;
`else
  assign last_s = onehot_s;
`endif

  assign last = out_valid & last_s;
  assign y    = (out_valid & found_s) ? idx_s : '0;

  // Next-state logic: capture on acceptance, retire one bit per beat.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
`ifdef PRIO_ENC_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          pend_d = a;
          if (a != '0) begin
            state_d = EMIT;
          end else begin
`ifdef PRIO_ENC_ZERO_FLAG_EN
            state_d = EMIT;
            zero_d  = 1'b1;
`else
            state_d = IDLE;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_d = pend_q & ~clr_mask_s;
          if (last_s) begin
            state_d = IDLE;
`ifdef PRIO_ENC_ZERO_FLAG_EN
            zero_d  = 1'b0;
`endif
          end else begin
            state_d = EMIT;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  // State register; reset discards any partially drained vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
`ifdef PRIO_ENC_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
`ifdef PRIO_ENC_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

endmodule

// File: doc/prio_enc_serializer.md
# prio_enc_serializer

Parametrised, registered multi-hit encoder for the encoder family. It accepts an N-bit request vector through a valid/ready handshake and emits the binary index of every set bit, lowest index first, one index per beat. Each beat carries a `last` marker. It generalises the fixed 8:3 enabled encoder to any width and to multiple simultaneous hits, and sits between a request/status bus and downstream per-index handlers.

## Interface
- `N`, default 8: request vector width; legal range is N ≥ 2.
- `W`, localparam, equal to $clog2(N): index width, not overridable.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  enable; gates acceptance of new vectors only
- `in_valid`  in  1  request vector `a` is valid
- `in_ready`  out  1  block can accept a vector this cycle
- `a`  in  N  request vector; bit i set means index i is requested
- `out_valid`  out  1  `y` holds a valid index
- `out_ready`  in  1  consumer accepts the current beat
- `y`  out  W  encoded index of the lowest pending bit
- `last`  out  1  current beat is the final one for this vector
- `zero`  out  1  current beat reports an all-zero vector; exists only when PRIO_ENC_ZERO_FLAG_EN is defined
- `busy`  out  1  a vector is being drained

## Operation
- State machine with two states:
  - IDLE: `in_ready = en & ~rst`.
  - EMIT: `in_ready = 0`.
- Accept when `in_valid & in_ready`; the pending register `pend` loads `a`.
  - If `a != 0`, the next state is EMIT.
  - If `a == 0`, handling depends on Configuration.
- Outputs in EMIT:
  - `out_valid = 1`
  - `y` = index of the lowest set bit of `pend`
  - `last = 1` when `pend` has exactly one bit set
- Beat transfer happens when `out_valid & out_ready`:
  - the bit at `y` is cleared in `pend`;
  - if `last` is high, the next state is IDLE.
- `en` low:
  - blocks new acceptance;
  - an in-flight vector keeps draining;
  - `en` has no effect on the output side.
- `out_valid` and `in_ready` never depend combinationally on each other.
- `y` and `last` are decoded from registered `pend` only; there is no combinational path from `a` to any output.
- `in_valid` dropping or `a` changing while in EMIT is ignored, because the vector was captured at acceptance.
- When `out_valid` is 0, `y`, `last` and `zero` are driven to 0.
- `busy = (state == EMIT)`.

## Timing
- Reset values, applied on the first edge with `rst` high:
  - state = IDLE, `pend` = 0
  - `out_valid` = 0, `y` = 0, `last` = 0, `zero` = 0, `busy` = 0
  - `in_ready` = 0 while `rst` is asserted
- Reset mid-drain discards the remaining bits. No partial beat appears after reset.
- Latency: a vector accepted at edge t gives its first `out_valid` in the cycle after edge t.
- Throughput with `out_ready` held high: one beat per cycle. A vector with k set bits occupies k cycles in EMIT, plus 1 cycle in IDLE before the next acceptance.
- Backpressure: while `out_ready` is 0, `y`, `last` and `out_valid` hold stable.
- Boundary cases:
  - `a` = all ones gives N beats, with indices 0 through N−1.
  - A single set bit at index N−1 gives `y = N−1` and `last = 1` on the first beat.

## Configuration
- `PRIO_ENC_ZERO_FLAG_EN` defined:
  - An accepted all-zero vector enters EMIT.
  - It produces exactly one beat with `y = 0`, `zero = 1`, `last = 1`.
  - `zero` is 0 on all other beats.
- Not defined:
  - An accepted all-zero vector is consumed and dropped; the state stays IDLE.
  - `in_ready` stays high and no beat is produced.
  - The `zero` port is absent.

## Structure
- Package `enc_pkg`:
  - state enum typedef (IDLE, EMIT);
  - function `enc_idx_w(N)` returning $clog2(N).
- Sub-module `prio_lsb_find`:
  - parametrised by N;
  - combinational lowest-set-bit finder;
  - outputs index (W bits), `found`, and `onehot` (true when exactly one bit is set).
  - Its `onehot` output drives `last`.

## Test plan
- Reset, N=8:
  - Hold `rst=1` for 2 cycles → `out_valid=0`, `y=0`, `last=0`, `in_ready=0`.
  - Release with `en=1` → `in_ready=1` in the next cycle.
- Single hit:
  - Present `a=8'b00000100` with `out_ready=1` → one beat with `y=2`, `last=1`.
  - `in_ready` returns high in the following cycle.
- Multi-hit:
  - Present `a=8'b10010010` with `out_ready=1` → consecutive beats `y=1`, `4`, `7`.
  - `last` is high only with `y=7`.
- Backpressure:
  - Same vector, `out_ready=0` for 3 cycles after the first beat appears → `y=1` holds with `out_valid=1`.
  - Then the sequence completes with `y=1`, `4`, `7`.
- Enable:
  - `en=0` with `in_valid=1` → `in_ready=0` and no beat.
  - Drop `en` during the drain of `8'b11000000` → beats `6` then `7` still appear.
- Zero vector and reset mid-drain:
  - `a=0` with the macro defined → one beat with `y=0`, `zero=1`, `last=1`.
  - `a=0` without the macro → no beat.
  - `rst` pulse during the drain of `8'hFF` → `out_valid=0` on the next cycle, with no stale indices afterwards.
